// File: rtl/contador_btn_ctrl_pkg.sv
// Shared definitions for the counter button front-end: debounce FSM state
// encodings and default timing values.
package contador_btn_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_DEB_REL   = 2'd3
  } btn_state_t;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_REP_DELAY  = 16;
  localparam int DEF_REP_PERIOD = 4;

endpackage

// File: rtl/contador_btn_ctrl_if.sv
// Button/step bundle between the board-side driver and the button sequencer.
// master: drives raw buttons and enable; slave: the sequencer producing steps.
interface contador_btn_ctrl_if;

  logic btn_up;
  logic btn_down;
  logic enable;
  logic step_up;
  logic step_down;
  logic conflict;
  logic up_held;
  logic down_held;

  modport master (
    output btn_up, btn_down, enable,
    input  step_up, step_down, conflict, up_held, down_held
  );

  modport slave (
    input  btn_up, btn_down, enable,
    output step_up, step_down, conflict, up_held, down_held
  );

endinterface

// File: rtl/contador_btn_ctrl_btn_debounce.sv
// One pushbutton channel: 2-flop synchroniser, debounce FSM and, when
// AUTO_REPEAT_EN is defined, auto-repeat while the button stays pressed.
// strobe is a registered one-cycle accept pulse; held is the debounced level.
module btn_debounce
  import contador_btn_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic strobe,
  output logic held
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  // Reject configurations the counters cannot honour.
  if (DEB_CYCLES < 1 || REP_PERIOD < 1 || REP_DELAY < 1) begin : g_bad_cfg
    $error("btn_debounce: DEB_CYCLES, REP_DELAY and REP_PERIOD must be >= 1");
  end

  logic          sync_p0;
  logic          sync_p1;
  btn_state_t    state;
  btn_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          accept;
  logic          rep_fire;

  // Synchroniser: raw button -> sync_p0 -> sync_p1 (metastability guard).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce state and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: a level must be seen DEB_CYCLES times in a row to be taken;
  // the counter stops at its terminal value rather than wrapping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sync_p1) begin
          if (DEB_CYCLES <= 1) begin
            state_nxt = ST_PRESSED;
            accept    = 1'b1;
          end else begin
            state_nxt = ST_DEB_PRESS;
            cnt_nxt   = CW'(1);
          end
        end
      end
      ST_DEB_PRESS: begin
        if (!sync_p1) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt >= CW'(DEB_CYCLES - 1)) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = '0;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_PRESSED: begin
        if (!sync_p1) begin
          if (DEB_CYCLES <= 1) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DEB_REL;
            cnt_nxt   = CW'(1);
          end
        end
      end
      ST_DEB_REL: begin
        if (sync_p1) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = '0;
        end else if (cnt >= CW'(DEB_CYCLES - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_phase;
  logic          rep_active;

  // Repeat timer only runs while the button stays pressed.
  assign rep_active = (state == ST_PRESSED) && sync_p1;
  assign rep_fire   = rep_active &&
                      (rep_phase ? (rep_cnt == RW'(REP_PERIOD - 1))
                                 : (rep_cnt == RW'(REP_DELAY - 1)));

  // Initial delay phase, then periodic phase; cleared on leaving PRESSED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (!rep_active) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Accept/repeat strobe register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe <= 1'b0;
    end else begin
      strobe <= accept | rep_fire;
    end
  end

  assign held = (state == ST_PRESSED) || (state == ST_DEB_REL);

endmodule

// File: rtl/contador_btn_ctrl.sv
// Front-end sequencer for the 4-bit up/down counter: debounces the UP/DOWN
// buttons, arbitrates simultaneous accepts and emits registered one-cycle
// step pulses. Optional auto-repeat is enabled with the AUTO_REPEAT_EN macro.
module contador_btn_ctrl
  import contador_btn_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD
) (
  input logic                clk,
  input logic                rst,
  contador_btn_ctrl_if.slave bus
);

  logic up_strobe;
  logic up_level;
  logic down_strobe;
  logic down_level;
  logic step_up_p0;
  logic step_down_p0;
  logic conflict_p0;
  logic up_held_p0;
  logic down_held_p0;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .REP_DELAY  (REP_DELAY),
    .REP_PERIOD (REP_PERIOD)
  ) u_up (
    .clk    (clk),
    .rst    (rst),
    .btn    (bus.btn_up),
    .strobe (up_strobe),
    .held   (up_level)
  );

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .REP_DELAY  (REP_DELAY),
    .REP_PERIOD (REP_PERIOD)
  ) u_down (
    .clk    (clk),
    .rst    (rst),
    .btn    (bus.btn_down),
    .strobe (down_strobe),
    .held   (down_level)
  );

  // Arbiter + enable gate: a tie drops both steps and flags a conflict,
  // which is reported even while stepping is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_up_p0   <= 1'b0;
      step_down_p0 <= 1'b0;
      conflict_p0  <= 1'b0;
      up_held_p0   <= 1'b0;
      down_held_p0 <= 1'b0;
    end else begin
      step_up_p0   <= bus.enable & up_strobe & ~down_strobe;
      step_down_p0 <= bus.enable & down_strobe & ~up_strobe;
      conflict_p0  <= up_strobe & down_strobe;
      up_held_p0   <= up_level;
      down_held_p0 <= down_level;
    end
  end

  assign bus.step_up   = step_up_p0;
  assign bus.step_down = step_down_p0;
  assign bus.conflict  = conflict_p0;
  assign bus.up_held   = up_held_p0;
  assign bus.down_held = down_held_p0;

endmodule
